snake_step_ctrl: RTL

- Sequences one snake game step per move tick. Generates the tick from pause/slow, latches a legal direction, computes the next head cell, and scans the body one segment per cycle for self-collision.
- Checks wall and food, then issues a single commit strobe (shift, optionally grow) to the snake datapath.
- Sits between the direction/fsm blocks and the snake body register file. Also feeds hit_boundary, hit_self and get_food to fsm, food and score.

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_step_tick_gen.sv | 26 ++
 rtl/snake_step_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared game/direction codes, grid geometry and step FSM states
package snake_pkg;
    localparam logic [1:0] RUNNING = 2'b00;
    localparam logic [1:0] DIE     = 2'b01;
    localparam logic [1:0] INITIAL = 2'b10;
    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] RIGHT = 2'b10;
    localparam logic [1:0] LEFT  = 2'b11;
    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int MAX_LEN = 64;
    typedef enum logic [2:0] {IDLE, WAIT_TICK, LATCH, SCAN, EVAL, COMMIT, HALT} step_state_t;
    function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
        return dir ^ 2'b01;
    endfunction
endpackage

// File: rtl/snake_step_tick_gen.sv
// snake_step_tick_gen: move-tick counter with pause hold and fast/slow period select
module snake_step_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_FAST = 5_000_000,
    parameter int TICK_SLOW = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pause,
    input  logic slow,
    output logic tick
);
    localparam int CW = $clog2(TICK_SLOW > TICK_FAST ? TICK_SLOW : TICK_FAST);
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    assign last = slow ? CW'(TICK_SLOW - 1) : CW'(TICK_FAST - 1);
    // a counter already past a freshly shortened period fires at once
    assign tick = !clear && !pause && cnt >= last;
    // count armed, unpaused cycles; a tick or clear restarts from zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear || tick) cnt <= '0;
        else if (!pause) cnt <= cnt + 1'b1;
endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: sequences one snake move per tick with wall, self and food checks
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_FAST = 5_000_000,
    parameter int TICK_SLOW = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       pause,
    input  logic       slow,
    input  logic [1:0] next_direction,
    input  logic [5:0] snake_length,
    input  logic [4:0] seg_x,
    input  logic [4:0] seg_y,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    output logic [5:0] seg_idx,
    output logic [1:0] cur_dir,
    output logic [4:0] new_head_x,
    output logic [4:0] new_head_y,
    output logic       shift_en,
    output logic       grow_en,
    output logic       get_food,
    output logic       hit_boundary,
    output logic       hit_self,
    output logic       step_done
);
    step_state_t state, state_n;
    logic [1:0] dir, cur_dir_n;
    logic [4:0] hx, hy, nhx_n, nhy_n;
    logic [5:0] seg_idx_n, scan_end, scan_end_n;
    logic [6:0] len;
    logic eat, eat_n, eat_c, wall, full, tick, hb_n, hs_n, done_n;

    snake_step_tick_gen #(.TICK_FAST(TICK_FAST), .TICK_SLOW(TICK_SLOW)) u_tick (
        .clk(clk),
        .rst(rst),
        .clear(state != WAIT_TICK),
        .pause(pause),
        .slow(slow),
        .tick(tick)
    );

    // a full 64-segment snake wraps to 0 on the 6-bit length port
    assign len = (snake_length == '0) ? 7'(MAX_LEN) : {1'b0, snake_length};
    assign full = len >= 7'(MAX_LEN);
    assign dir = (next_direction == reverse_dir(cur_dir)) ? cur_dir : next_direction;
    assign hx = dir == RIGHT ? seg_x + 5'd1 : dir == LEFT ? seg_x - 5'd1 : seg_x;
    assign hy = dir == DOWN ? seg_y + 5'd1 : dir == UP ? seg_y - 5'd1 : seg_y;
    assign wall = (dir == LEFT && seg_x == '0) || (dir == RIGHT && seg_x == 5'(GRID_W - 1)) ||
                  (dir == UP && seg_y == '0) || (dir == DOWN && seg_y == 5'(GRID_H - 1));
    assign eat_c = hx == food_x && hy == food_y;
    assign shift_en = state == COMMIT;
    assign get_food = shift_en && eat;
    assign grow_en = get_food && !full;

    // next-state and step bookkeeping; leaving RUNNING overrides everything
    always_comb begin
        state_n = state;
        cur_dir_n = cur_dir;
        nhx_n = new_head_x;
        nhy_n = new_head_y;
        seg_idx_n = seg_idx;
        scan_end_n = scan_end;
        eat_n = eat;
        hb_n = hit_boundary;
        hs_n = hit_self;
        if (game_state != RUNNING) begin
            state_n = IDLE;
            seg_idx_n = '0;
            if (game_state == INITIAL) begin
                cur_dir_n = RIGHT;
                hb_n = 1'b0;
                hs_n = 1'b0;
            end
        end else begin
            case (state)
                IDLE: state_n = WAIT_TICK;
                WAIT_TICK: state_n = tick ? LATCH : WAIT_TICK;
                LATCH: begin
                    cur_dir_n = dir;
                    if (wall) begin
                        hb_n = 1'b1;
                        state_n = HALT;
                    end else begin
                        nhx_n = hx;
                        nhy_n = hy;
                        eat_n = eat_c;
                        // the tail cell vacates unless this step grows
                        scan_end_n = 6'(len - (eat_c ? 7'd1 : 7'd2));
                        seg_idx_n = 6'd1;
                        state_n = (len < (eat_c ? 7'd2 : 7'd3)) ? EVAL : SCAN;
                    end
                end
                SCAN: begin
                    if (seg_x == new_head_x && seg_y == new_head_y) begin
                        hs_n = 1'b1;
                        state_n = HALT;
                    end else if (seg_idx == scan_end) begin
                        state_n = EVAL;
                    end else begin
                        seg_idx_n = seg_idx + 6'd1;
                    end
                end
                EVAL: begin
                    seg_idx_n = '0;
                    state_n = COMMIT;
                end
                COMMIT: state_n = WAIT_TICK;
                default: state_n = HALT;
            endcase
        end
        done_n = state_n == COMMIT || (state_n == HALT && state != HALT);
    end

    // state and step registers; reset abandons any step in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cur_dir <= RIGHT;
            new_head_x <= '0;
            new_head_y <= '0;
            seg_idx <= '0;
            scan_end <= '0;
            eat <= 1'b0;
            hit_boundary <= 1'b0;
            hit_self <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state <= state_n;
            cur_dir <= cur_dir_n;
            new_head_x <= nhx_n;
            new_head_y <= nhy_n;
            seg_idx <= seg_idx_n;
            scan_end <= scan_end_n;
            eat <= eat_n;
            hit_boundary <= hb_n;
            hit_self <= hs_n;
            step_done <= done_n;
        end
endmodule
